// File: rtl/data_compare_seq.sv
// data_compare_seq: multi-cycle MSB-first magnitude comparator, CHUNK bits per clock, early exit
module data_compare_seq #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             iClk,
   input  logic             iRst,
   input  logic             iStart,
   input  logic             iSigned,
   input  logic [WIDTH-1:0] iData_a,
   input  logic [WIDTH-1:0] iData_b,
   output logic             oBusy,
   output logic             oDone,
   output logic [2:0]       oData
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
   typedef enum logic {IDLE, RUN} state_t;
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [2:0] data_q, data_d;
   logic done_q, done_d;
   logic [CHUNK-1:0] ca, cb;
   logic last;
   // Next state: capture on start (MSB flipped for signed), then compare the top chunk and shift
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      a_d = a_q;
      b_d = b_q;
      data_d = data_q;
      done_d = 1'b0;
      ca = a_q[WIDTH-1 -: CHUNK];
      cb = b_q[WIDTH-1 -: CHUNK];
      last = cnt_q == CW'(NCHUNK - 1);
      if (state_q == IDLE) begin
         if (iStart) begin
            state_d = RUN;
            cnt_d = '0;
            a_d = iData_a ^ {iSigned, {(WIDTH-1){1'b0}}};
            b_d = iData_b ^ {iSigned, {(WIDTH-1){1'b0}}};
         end
      end else if (ca != cb || last) begin
         data_d = ca > cb ? 3'b100 : ca < cb ? 3'b001 : 3'b010;
         done_d = 1'b1;
         state_d = IDLE;
      end else begin
         cnt_d = cnt_q + 1'b1;
         a_d = a_q << CHUNK;
         b_d = b_q << CHUNK;
      end
   end
   // State and result registers, cleared asynchronously
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state_q <= IDLE;
         cnt_q <= '0;
         a_q <= '0;
         b_q <= '0;
         data_q <= 3'b000;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         a_q <= a_d;
         b_q <= b_d;
         data_q <= data_d;
         done_q <= done_d;
      end
   end
   assign oBusy = state_q == RUN;
   assign oDone = done_q;
   assign oData = data_q;
endmodule
